// File: rtl/fifo_test_sequencer.sv
// fifo_test_sequencer
// Drives the asymmetric-FIFO demo through a fixed bring-up sequence on led_clk:
// wait for PLL lock and FIFO reset release, fill to full, drain to empty, then
// stream with both paths open. It reaches a sticky PASS or FAIL verdict and
// drives the status LED.
//
// Ports
//   led_clk       in   sequencer clock
//   sys_rst       in   asynchronous reset, active-high
//   start         in   level, launches the sequence from IDLE (led_clk domain)
//   clear         in   level, returns PASS/FAIL to IDLE (led_clk domain)
//   pll_lock      in   async, PLL locked
//   rst_busy      in   async, OR of the FIFO reset-busy flags
//   fifo_full     in   async, FIFO full flag
//   fifo_empty    in   async, FIFO empty flag
//   rdata_error   in   async, sticky read-data compare error
//   wr_gate_o     out  write enable gate
//   rd_gate_o     out  read enable gate
//   state_o       out  current state code
//   pass_o        out  sticky pass
//   fail_o        out  sticky fail
//   led_status_o  out  status LED
//
// state    | code | meaning
// IDLE     | 0    | waiting for start
// WAIT_RDY | 1    | waiting for PLL lock and FIFO reset release
// FILL     | 2    | writes open until the FIFO reports full
// DRAIN    | 3    | reads open until the FIFO reports empty
// STREAM   | 4    | writes and reads open for STREAM_CYCLES cycles
// PASS     | 5    | sequence completed without error (sticky)
// FAIL     | 6    | error, lock loss or phase timeout (sticky)

module fifo_test_sequencer #(
  parameter int SYNC_STAGE    = 2,
  parameter int TIMEOUT_W     = 20,
  parameter int STREAM_CYCLES = 1024,
  parameter int BLINK_W       = 20
) (
  input  logic       led_clk,
  input  logic       sys_rst,
  input  logic       start,
  input  logic       clear,
  input  logic       pll_lock,
  input  logic       rst_busy,
  input  logic       fifo_full,
  input  logic       fifo_empty,
  input  logic       rdata_error,
  output logic       wr_gate_o,
  output logic       rd_gate_o,
  output logic [2:0] state_o,
  output logic       pass_o,
  output logic       fail_o,
  output logic       led_status_o
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_RDY = 3'd1,
    S_FILL     = 3'd2,
    S_DRAIN    = 3'd3,
    S_STREAM   = 3'd4,
    S_PASS     = 3'd5,
    S_FAIL     = 3'd6
  } state_t;

  // A single flop stage is never a safe synchronizer, so clamp to two.
  localparam int SS    = (SYNC_STAGE < 2) ? 2 : SYNC_STAGE;
  localparam int STR_W = (STREAM_CYCLES > 1) ? $clog2(STREAM_CYCLES) : 1;

  state_t               state_q, state_d;
  logic [4:0]           sync_q [SS];
  logic                 lock_s, busy_s, full_s, empty_s, err_s;
  logic [TIMEOUT_W-1:0] tmo_q;
  logic                 timeout;
  logic [STR_W-1:0]     str_q;
  logic                 stream_done;
  logic [BLINK_W-1:0]   blink_q, blink_d;
  logic                 led_d;

  // Bit order in every chain stage: {lock, busy, full, empty, err}.
  always_ff @(posedge led_clk or posedge sys_rst) begin
    if (sys_rst) begin
      for (int i = 0; i < SS; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= {pll_lock, rst_busy, fifo_full, fifo_empty, rdata_error};
      for (int i = 1; i < SS; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign lock_s  = sync_q[SS-1][4];
  assign busy_s  = sync_q[SS-1][3];
  assign full_s  = sync_q[SS-1][2];
  assign empty_s = sync_q[SS-1][1];
  assign err_s   = sync_q[SS-1][0];

  assign timeout     = &tmo_q;
  assign stream_done = (str_q == STR_W'(STREAM_CYCLES - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (start) state_d = S_WAIT_RDY;
      S_WAIT_RDY: if (lock_s && !busy_s) state_d = S_FILL;
                  else if (timeout)      state_d = S_FAIL;
      // full wins over a simultaneous empty; a stray empty here is ignored.
      S_FILL:     if (full_s)            state_d = S_DRAIN;
                  else if (timeout)      state_d = S_FAIL;
      S_DRAIN:    if (empty_s)           state_d = S_STREAM;
                  else if (timeout)      state_d = S_FAIL;
      S_STREAM:   if (stream_done)       state_d = S_PASS;
      S_PASS,
      S_FAIL:     if (clear)             state_d = S_IDLE;
      default:                           state_d = S_FAIL;
    endcase
    // Error and lock loss override every phase transition, including PASS.
    if (err_s && (state_q inside {S_WAIT_RDY, S_FILL, S_DRAIN, S_STREAM}))
      state_d = S_FAIL;
    else if (!lock_s && (state_q inside {S_FILL, S_DRAIN, S_STREAM}))
      state_d = S_FAIL;
  end

  assign blink_d = blink_q + BLINK_W'(1);

  always_comb begin
    led_d = 1'b0;
    case (state_d)
      S_WAIT_RDY, S_FILL, S_DRAIN, S_STREAM: led_d = blink_d[BLINK_W-1];
      S_PASS:                                led_d = 1'b1;
      S_FAIL:                                led_d = blink_d[BLINK_W-3];
      default:                               led_d = 1'b0;
    endcase
  end

  always_ff @(posedge led_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q      <= S_IDLE;
      tmo_q        <= '0;
      str_q        <= '0;
      blink_q      <= '0;
      wr_gate_o    <= 1'b0;
      rd_gate_o    <= 1'b0;
      pass_o       <= 1'b0;
      fail_o       <= 1'b0;
      led_status_o <= 1'b0;
    end else begin
      state_q <= state_d;
      blink_q <= blink_d;

      if (state_d != state_q)
        tmo_q <= '0;
      else if ((state_q inside {S_WAIT_RDY, S_FILL, S_DRAIN}) && !timeout)
        tmo_q <= tmo_q + TIMEOUT_W'(1);

      if (state_d == S_STREAM && state_q != S_STREAM)
        str_q <= '0;
      else if (state_q == S_STREAM)
        str_q <= str_q + STR_W'(1);

      // Decoded from the next state so outputs move on the same edge as state_o.
      wr_gate_o    <= (state_d == S_FILL)  || (state_d == S_STREAM);
      rd_gate_o    <= (state_d == S_DRAIN) || (state_d == S_STREAM);
      pass_o       <= (state_d == S_PASS);
      fail_o       <= (state_d == S_FAIL);
      led_status_o <= led_d;
    end
  end

  assign state_o = state_q;

endmodule
